// File: rtl/ibus_master_pkg.sv
// ibus_master_pkg: shared IBUS types, lane constants and the alignment helper
package ibus_master_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_WORD = 2'b01,
        SZ_LONG = 2'b10
    } IBUS_SIZE_t;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        DONE   = 2'b10
    } IBUS_STATE_t;

    localparam logic [3:0] IBUS_BA_BYTE0 = 4'b1000;
    localparam logic [3:0] IBUS_BA_WORD0 = 4'b1100;

    // Reserved size 11 is folded into the misaligned class so it never reaches the bus
    function automatic logic misaligned(input logic [1:0] a, input logic [1:0] sz);
        return (sz == 2'b11) || (sz == SZ_WORD && a[0]) || (sz == SZ_LONG && a != 2'b00);
    endfunction

endpackage

// File: rtl/ibus_master_if.sv
// ibus_master_if: CPU data-port and IBUS signal bundle seen by the initiator
interface ibus_master_if;
    logic [31:0] CPU_A;
    logic [31:0] CPU_DI;
    logic [1:0]  CPU_SZ;
    logic        CPU_SGN;
    logic        CPU_WE;
    logic        CPU_REQ;
    logic [31:0] CPU_DO;
    logic        CPU_ACK;
    logic        CPU_ERR;
    logic [31:0] IBUS_A;
    logic [31:0] IBUS_DO;
    logic [31:0] IBUS_DI;
    logic [3:0]  IBUS_BA;
    logic        IBUS_WE;
    logic        IBUS_REQ;
    logic        IBUS_BUSY;
    logic        IBUS_ACT;
    logic        IBUS_CE_F;

    modport master (
        input  CPU_A, CPU_DI, CPU_SZ, CPU_SGN, CPU_WE, CPU_REQ, IBUS_DI, IBUS_BUSY, IBUS_ACT,
        output CPU_DO, CPU_ACK, CPU_ERR, IBUS_A, IBUS_DO, IBUS_BA, IBUS_WE, IBUS_REQ, IBUS_CE_F
    );

    modport slave (
        output CPU_A, CPU_DI, CPU_SZ, CPU_SGN, CPU_WE, CPU_REQ, IBUS_DI, IBUS_BUSY, IBUS_ACT,
        input  CPU_DO, CPU_ACK, CPU_ERR, IBUS_A, IBUS_DO, IBUS_BA, IBUS_WE, IBUS_REQ, IBUS_CE_F
    );
endinterface

// File: rtl/ibus_master_lane.sv
// ibus_lane: byte-lane/write-replication generator and read-lane extractor/extender
module ibus_lane
    import ibus_master_pkg::*;
(
    input  logic [1:0]  a_i,
    input  logic [1:0]  sz_i,
    input  logic        sgn_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  ba_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o
);
    logic [7:0]  byte_l;
    logic [15:0] word_l;

    // Big-endian lanes: address offset 0 is the most significant byte
    always_comb begin
        byte_l  = rdata_i[{~a_i, 3'b111} -: 8];
        word_l  = a_i[1] ? rdata_i[15:0] : rdata_i[31:16];
        ba_o    = sz_i == SZ_BYTE ? IBUS_BA_BYTE0 >> a_i :
                  sz_i == SZ_WORD ? IBUS_BA_WORD0 >> {a_i[1], 1'b0} : 4'b1111;
        wdata_o = sz_i == SZ_BYTE ? {4{wdata_i[7:0]}} :
                  sz_i == SZ_WORD ? {2{wdata_i[15:0]}} : wdata_i;
        rdata_o = sz_i == SZ_BYTE ? {{24{sgn_i & byte_l[7]}}, byte_l} :
                  sz_i == SZ_WORD ? {{16{sgn_i & word_l[15]}}, word_l} : rdata_i;
    end
endmodule

// File: rtl/ibus_master.sv
// ibus_master: turns single CPU data accesses into IBUS cycles with wait, claim and timeout handling
module ibus_master
    import ibus_master_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          CE_R,
    input  logic          CE_F,
    ibus_master_if.master bus
);
    IBUS_STATE_t state_q;
    logic [31:0] addr_q, wd_q, do_q;
    logic [3:0]  ba_q;
    logic [1:0]  sz_q;
    logic        sgn_q, we_q, req_q, ack_q, err_q;
    logic [7:0]  cnt_q, cnt_d;
    logic [1:0]  lane_a, lane_sz;
    logic        lane_sgn, misal, abort;
    logic [3:0]  ba_d;
    logic [31:0] wd_d, rd_d;

    ibus_lane u_lane (
        .a_i     (lane_a),
        .sz_i    (lane_sz),
        .sgn_i   (lane_sgn),
        .wdata_i (bus.CPU_DI),
        .rdata_i (bus.IBUS_DI),
        .ba_o    (ba_d),
        .wdata_o (wd_d),
        .rdata_o (rd_d)
    );

    // Lanes follow live CPU operands while idle and the latched ones during the bus cycle
    always_comb begin
        lane_a   = state_q == IDLE ? bus.CPU_A[1:0] : addr_q[1:0];
        lane_sz  = state_q == IDLE ? bus.CPU_SZ : sz_q;
        lane_sgn = state_q == IDLE ? bus.CPU_SGN : sgn_q;
        misal    = misaligned(bus.CPU_A[1:0], bus.CPU_SZ);
        cnt_d    = cnt_q + 8'(cnt_q != 8'hFF);
        abort    = bus.IBUS_BUSY ? cnt_d >= 8'(TIMEOUT) : !bus.IBUS_ACT;
    end

    // Access FSM; ACK/ERR drop on the first CLK in DONE so the pulse is one CLK wide
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wd_q    <= '0;
            do_q    <= '0;
            ba_q    <= '0;
            sz_q    <= '0;
            sgn_q   <= 1'b0;
            we_q    <= 1'b0;
            req_q   <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            if (state_q == DONE) begin
                ack_q <= 1'b0;
                err_q <= 1'b0;
            end
            if (CE_R) begin
                case (state_q)
                    IDLE: begin
                        if (bus.CPU_REQ && !ack_q) begin
                            if (misal) begin
                                ack_q   <= 1'b1;
                                err_q   <= 1'b1;
                                do_q    <= '0;
                                state_q <= DONE;
                            end else begin
                                addr_q  <= bus.CPU_A;
                                sz_q    <= bus.CPU_SZ;
                                sgn_q   <= bus.CPU_SGN;
                                we_q    <= bus.CPU_WE;
                                ba_q    <= ba_d;
                                wd_q    <= wd_d;
                                req_q   <= 1'b1;
                                cnt_q   <= '0;
                                state_q <= ACCESS;
                            end
                        end
                    end
                    ACCESS: begin
                        if (bus.IBUS_BUSY) cnt_q <= cnt_d;
                        if (!bus.IBUS_BUSY || abort) begin
                            req_q   <= 1'b0;
                            we_q    <= 1'b0;
                            ack_q   <= 1'b1;
                            err_q   <= abort;
                            state_q <= DONE;
                            if (!we_q) do_q <= abort ? '0 : rd_d;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign bus.CPU_DO    = do_q;
    assign bus.CPU_ACK   = ack_q;
    assign bus.CPU_ERR   = err_q;
    assign bus.IBUS_A    = addr_q;
    assign bus.IBUS_DO   = wd_q;
    assign bus.IBUS_BA   = ba_q;
    assign bus.IBUS_WE   = we_q;
    assign bus.IBUS_REQ  = req_q;
    assign bus.IBUS_CE_F = CE_F;
endmodule

// File: tb/tb_ibus_master.sv
// tb_ibus_master: randomized scoreboard bench with a behavioural slave and access model
module tb_ibus_master;
    localparam int T = 4;

    logic CLK = 1'b0;
    logic RST_N = 1'b0;
    logic CE_R = 1'b0;
    logic CE_F = 1'b1;

    ibus_master_if bus ();

    ibus_master #(.TIMEOUT(T)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .CE_R  (CE_R),
        .CE_F  (CE_F),
        .bus   (bus)
    );

    typedef struct { logic [31:0] d; logic e; logic c; int lat; } cpu_t;
    typedef struct { logic [31:0] a; logic [3:0] ba; logic [31:0] wd; logic we; int hold; } bus_t;

    cpu_t cq[$];
    bus_t bq[$];
    int n_cmp = 0;
    int n_bad = 0;
    int s_busy = 0;
    logic s_act = 1'b0;
    logic [31:0] s_rd = '0;

    // CE_R is high on every other rising CLK edge; it changes 1 time unit after posedge
    initial forever begin
        #5 CLK = 1'b1;
        #1 CE_R = ~CE_R;
        CE_F = ~CE_R;
        #4 CLK = 1'b0;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    // Behavioural slave: presents BUSY for s_busy sampled CE_R edges, then ACT
    always @(negedge CLK) begin
        bus.IBUS_DI = s_rd;
        if (!bus.IBUS_REQ) begin
            bus.IBUS_BUSY = 1'b0;
            bus.IBUS_ACT  = 1'b0;
        end else if (CE_R) begin
            bus.IBUS_BUSY = s_busy > 0;
            bus.IBUS_ACT  = s_act;
            if (s_busy > 0) s_busy--;
        end
    end

    logic req_prev = 1'b0;
    int hold = 0;
    bus_t cur;

    // Bus-side monitor: checks cycle contents on REQ rise and its length on REQ fall
    always @(negedge CLK) begin
        if (bus.IBUS_REQ && !req_prev) begin
            hold = 0;
            if (bq.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL spurious_bus_cycle: IBUS_REQ got 1 want 0");
            end else begin
                cur = bq.pop_front();
                chk("ibus_a", bus.IBUS_A, cur.a);
                chk("ibus_ba", 32'(bus.IBUS_BA), 32'(cur.ba));
                chk("ibus_do", bus.IBUS_DO, cur.wd);
                chk("ibus_we", 32'(bus.IBUS_WE), 32'(cur.we));
            end
        end
        if (bus.IBUS_REQ && !CE_R) hold++;
        if (!bus.IBUS_REQ && req_prev && RST_N) begin
            chk("req_hold", 32'(hold), 32'(cur.hold));
            chk("we_release", 32'(bus.IBUS_WE), 32'd0);
        end
        req_prev = bus.IBUS_REQ;
    end

    logic ack_prev = 1'b0;
    int lat = 0;
    cpu_t ce;

    // CPU-side monitor: pops the expected response for every ACK
    always @(negedge CLK) begin
        if (!RST_N) lat = 0;
        else if (bus.CPU_REQ && !CE_R) lat++;
        if (bus.CPU_ACK) begin
            chk("ack_width", 32'(ack_prev), 32'd0);
            if (cq.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_ack: CPU_ACK got 1 want 0");
            end else begin
                ce = cq.pop_front();
                chk("cpu_err", 32'(bus.CPU_ERR), 32'(ce.e));
                if (ce.c) chk("cpu_do", bus.CPU_DO, ce.d);
                chk("ack_latency", 32'(lat), 32'(ce.lat));
            end
            lat = 0;
        end
        ack_prev = bus.CPU_ACK;
    end

    task automatic drive(input logic [31:0] a, input logic [1:0] sz, input logic sgn, input logic we,
                         input logic [31:0] di);
        while (!CE_R) @(negedge CLK);
        bus.CPU_A   = a;
        bus.CPU_SZ  = sz;
        bus.CPU_SGN = sgn;
        bus.CPU_WE  = we;
        bus.CPU_DI  = di;
        bus.CPU_REQ = 1'b1;
    endtask

    task automatic txn(input logic [31:0] a, input logic [1:0] sz, input logic sgn, input logic we,
                       input logic [31:0] di, input int busy, input logic act, input logic [31:0] rd);
        cpu_t c;
        bus_t b;
        int k;
        int n;
        logic mis;
        logic [31:0] v;
        k = int'(a[1:0]);
        mis = sz == 2'd3 || (sz == 2'd1 && a[0]) || (sz == 2'd2 && k != 0);
        case (sz)
            2'd0: begin
                v = (rd >> (8 * (3 - k))) & 32'hFF;
                if (sgn && v[7]) v = v | 32'hFFFF_FF00;
                b.ba = 4'(1 << (3 - k));
                b.wd = (di & 32'hFF) * 32'h0101_0101;
            end
            2'd1: begin
                v = (rd >> (a[1] ? 0 : 16)) & 32'hFFFF;
                if (sgn && v[15]) v = v | 32'hFFFF_0000;
                b.ba = a[1] ? 4'h3 : 4'hC;
                b.wd = (di & 32'hFFFF) * 32'h0001_0001;
            end
            default: begin
                v = rd;
                b.ba = 4'hF;
                b.wd = di;
            end
        endcase
        b.a    = a;
        b.we   = we;
        b.hold = busy >= T ? T : busy + 1;
        c.e    = mis || busy >= T || !act;
        c.d    = c.e ? 32'd0 : v;
        c.c    = !we || mis;
        c.lat  = mis ? 1 : b.hold + 1;
        cq.push_back(c);
        if (!mis) bq.push_back(b);
        s_busy = busy;
        s_act  = act;
        s_rd   = rd;
        drive(a, sz, sgn, we, di);
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (!bus.CPU_ACK && n < 200);
        if (!bus.CPU_ACK) begin
            n_cmp++;
            n_bad++;
            $display("FAIL ack_timeout: CPU_ACK got 0 want 1 within 200 clocks");
        end
        @(negedge CLK);
        bus.CPU_REQ = 1'b0;
        repeat ($urandom_range(2, 5)) @(negedge CLK);
    endtask

    logic [31:0] ra, rdi, rrd;
    logic [1:0]  rsz;
    logic        rsgn, rwe, ract;
    int          rbusy;
    bus_t        rb;

    initial begin
        bus.CPU_A   = '0;
        bus.CPU_DI  = '0;
        bus.CPU_SZ  = '0;
        bus.CPU_SGN = 1'b0;
        bus.CPU_WE  = 1'b0;
        bus.CPU_REQ = 1'b0;
        repeat (3) @(negedge CLK);
        chk("rst_cpu_do", bus.CPU_DO, 32'd0);
        chk("rst_flags", 32'({bus.CPU_ACK, bus.CPU_ERR, bus.IBUS_WE, bus.IBUS_REQ}), 32'd0);
        chk("rst_ibus_a", bus.IBUS_A, 32'd0);
        chk("rst_ibus_do", bus.IBUS_DO, 32'd0);
        chk("rst_ibus_ba", 32'(bus.IBUS_BA), 32'd0);
        #2 RST_N = 1'b1;
        repeat (2) @(negedge CLK);

        txn(32'hFFFF_FE80, 2'd1, 1'b0, 1'b1, 32'h0000_5A40, 0, 1'b1, 32'h0);
        txn(32'hFFFF_FE83, 2'd0, 1'b1, 1'b0, 32'h0, 0, 1'b1, 32'h0000_00F3);
        txn(32'hFFFF_FE83, 2'd0, 1'b0, 1'b0, 32'h0, 0, 1'b1, 32'h0000_00F3);
        txn(32'hFFFF_FE10, 2'd2, 1'b1, 1'b0, 32'h0, 3, 1'b1, 32'h89AB_CDEF);
        txn(32'hFFFF_FE81, 2'd1, 1'b0, 1'b0, 32'h0, 0, 1'b1, 32'h1234_5678);
        txn(32'hFFFF_FE82, 2'd3, 1'b0, 1'b1, 32'h0, 0, 1'b1, 32'h0);
        txn(32'h1234_5678, 2'd2, 1'b0, 1'b0, 32'h0, 0, 1'b0, 32'hDEAD_BEEF);
        txn(32'hFFFF_FE20, 2'd2, 1'b0, 1'b0, 32'h0, 10, 1'b1, 32'hCAFE_F00D);
        txn(32'hFFFF_FE92, 2'd1, 1'b1, 1'b0, 32'h0, 1, 1'b1, 32'h1234_8765);

        rb.a = 32'hFFFF_FC00;
        rb.ba = 4'hF;
        rb.wd = 32'h0BAD_F00D;
        rb.we = 1'b0;
        rb.hold = 0;
        bq.push_back(rb);
        s_busy = 3;
        s_act  = 1'b1;
        drive(32'hFFFF_FC00, 2'd2, 1'b0, 1'b0, 32'h0BAD_F00D);
        repeat (3) @(negedge CLK);
        chk("rst_mid_req_pre", 32'(bus.IBUS_REQ), 32'd1);
        #2 RST_N = 1'b0;
        #1;
        chk("rst_mid_req_drop", 32'(bus.IBUS_REQ), 32'd0);
        chk("rst_mid_no_ack", 32'(bus.CPU_ACK), 32'd0);
        bus.CPU_REQ = 1'b0;
        s_busy = 0;
        repeat (3) @(negedge CLK);
        #2 RST_N = 1'b1;
        repeat (2) @(negedge CLK);
        txn(32'hFFFF_FC04, 2'd2, 1'b0, 1'b0, 32'h0, 0, 1'b1, 32'h7654_3210);

        for (int i = 0; i < 150; i++) begin
            ra    = $urandom;
            rsz   = 2'($urandom_range(0, 3));
            rsgn  = 1'($urandom_range(0, 1));
            rwe   = 1'($urandom_range(0, 1));
            rdi   = $urandom;
            rrd   = $urandom;
            rbusy = $urandom_range(0, 5);
            ract  = $urandom_range(0, 6) != 0;
            if (rsz != 2'd3 && $urandom_range(0, 2) != 0)
                ra[1:0] = rsz == 2'd2 ? 2'b00 : rsz == 2'd1 ? {ra[1], 1'b0} : ra[1:0];
            txn(ra, rsz, rsgn, rwe, rdi, rbusy, ract, rrd);
        end

        repeat (10) @(negedge CLK);
        chk("cpu_queue_drained", 32'(cq.size()), 32'd0);
        chk("bus_queue_drained", 32'(bq.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/ibus_master.md
# ibus_master

Initiator side of the on-chip peripheral bus (IBUS). It turns single CPU data-port accesses (byte/word/long, read/write) into IBUS transactions toward the on-chip peripherals: WDT, FRT, SCI, DMAC and INTC.
- It generates byte lanes and replicated write data, waits out slave IBUS_BUSY, and steers and extends read data.
- It reports misaligned accesses, unclaimed addresses (no IBUS_ACT) and wait-state timeouts as errors.

## Interface
Parameters:
- TIMEOUT, 255: maximum CE_R-sampled busy cycles before the access is aborted with an error. Range 1..255.

Ports:
- CLK  in  1  system clock.
- RST_N  in  1  reset, asynchronous, active-low.
- CE_R  in  1  rising-phase clock enable. All state updates occur here.
- CE_F  in  1  falling-phase clock enable. The block does not use it; it is passed through to slaves, which register read data on it.
- CPU_A  in  32  access address.
- CPU_DI  in  32  write data, right-justified.
- CPU_SZ  in  2  access size: 00 byte, 01 word, 10 long; 11 is reserved and treated as misaligned.
- CPU_SGN  in  1  sign-extend read data (1) or zero-extend (0).
- CPU_WE  in  1  write (1) or read (0).
- CPU_REQ  in  1  access request. Held stable with all operands until CPU_ACK.
- CPU_DO  out  32  read data, right-justified and extended.
- CPU_ACK  out  1  one-CLK completion pulse.
- CPU_ERR  out  1  error flag, valid with CPU_ACK.
- IBUS_A  out  32  bus address.
- IBUS_DO  out  32  write data to slaves (the slave IBUS_DI).
- IBUS_DI  in  32  read data from slaves (the slave IBUS_DO).
- IBUS_BA  out  4  byte lanes, big-endian: bit3 = [31:24].
- IBUS_WE  out  1  write strobe.
- IBUS_REQ  out  1  bus request.
- IBUS_BUSY  in  1  slave wait.
- IBUS_ACT  in  1  a slave claims the address.

## Operation
- The FSM has three states: IDLE, ACCESS, DONE. Transitions are evaluated on CE_R only.
- IDLE:
  - Advances on CE_R with CPU_REQ=1 and CPU_ACK=0.
  - Misaligned request (word with A[0]=1, long with A[1:0]≠0, or SZ=11): no bus cycle. Set CPU_ACK=1, CPU_ERR=1, CPU_DO=0; go to DONE.
  - Aligned request: latch A/size/sign/WE. Drive IBUS_A=CPU_A, IBUS_WE=CPU_WE, IBUS_BA and IBUS_DO, set IBUS_REQ=1, clear the wait counter, go to ACCESS.
- Lane and write-data rules:
  - Byte: BA = 4'b1000 >> A[1:0]; IBUS_DO = {4{DI[7:0]}}.
  - Word: BA = A[1] ? 0011 : 1100; IBUS_DO = {2{DI[15:0]}}.
  - Long: BA = 1111; IBUS_DO = DI.
- ACCESS, evaluated on each CE_R:
  - IBUS_BUSY=1: increment the wait counter. When the counter reaches TIMEOUT, abort with an error.
  - Else, IBUS_ACT=0: abort with an error.
  - Else: complete. On a read, CPU_DO is the selected lane, extended per CPU_SGN. Byte lane = IBUS_DI[31-8*A[1:0] -: 8]; word lane = A[1] ? [15:0] : [31:16].
  - On completion or abort: IBUS_REQ=0, IBUS_WE=0, CPU_ACK=1, CPU_ERR=abort; go to DONE.
  - An aborted read returns CPU_DO=0.
- DONE:
  - CPU_ACK and CPU_ERR clear on the next CLK, so the pulse is one CLK wide.
  - The FSM returns to IDLE on the next CE_R.
  - A new request therefore starts no earlier than the second CE_R after ACK.
- The wait counter is 8 bits wide and saturates; it never wraps.
- When IBUS_REQ=0, IBUS_A, IBUS_DO and IBUS_BA hold their last values; IBUS_WE is 0.

## Timing
- Reset values: all outputs 0 (CPU_DO, CPU_ACK, CPU_ERR, IBUS_A, IBUS_DO, IBUS_BA, IBUS_WE, IBUS_REQ); FSM in IDLE; wait counter 0.
- Zero-wait access:
  - CPU_REQ is seen at CE_R edge n; IBUS_REQ is high from edge n.
  - The slave registers read data at the intervening CE_F.
  - Completion at CE_R edge n+1; CPU_ACK is high for 1 CLK after n+1.
- Each IBUS_BUSY=1 sample at CE_R adds one CE_R period.
- A write is committed at the CE_R where IBUS_REQ=1 and BUSY=0. The block releases IBUS_REQ at that same edge.
- RST_N low at any time, including mid-ACCESS: all state clears asynchronously and IBUS_REQ drops immediately. No ACK is issued for the abandoned access.
- Simultaneous BUSY=1 and ACT=0 at a CE_R: wait. BUSY takes priority.

## Structure
- Shared CPU package:
  - IBUS_SIZE_t enum: SZ_BYTE, SZ_WORD, SZ_LONG.
  - IBUS_STATE_t enum: IDLE, ACCESS, DONE.
  - Constants IBUS_BA_BYTE0 = 4'b1000, IBUS_BA_WORD0 = 4'b1100.
- One sub-module, ibus_lane: combinational BA/write-replication generator and read-lane extractor/extender. Reused by the DMAC bus port.

## Test plan
- Word write 0x5A40 to 0xFFFFFE80, ACT=1, BUSY=0 → IBUS_BA=1100, IBUS_DO=0x5A405A40, IBUS_WE=1 for one CE_R period; CPU_ACK after 2 CE_R edges, CPU_ERR=0.
- Byte read at 0xFFFFFE83, IBUS_DI=0x000000F3: CPU_SGN=1 → CPU_DO=0xFFFFFFF3; CPU_SGN=0 → 0x000000F3. BA=0001.
- Long read with BUSY held for 3 CE_R → REQ held 4 CE_R periods; CPU_DO=IBUS_DI; no error.
- Word read at 0xFFFFFE81 (misaligned) → IBUS_REQ never asserts; CPU_ACK=1 with CPU_ERR=1 and CPU_DO=0 at the first CE_R.
- Access to an unmapped address (ACT=0) → CPU_ERR=1 at the second CE_R. Separately, BUSY stuck high with TIMEOUT=4 → CPU_ERR=1 at the 4th busy sample.
- RST_N asserted mid-ACCESS → IBUS_REQ=0 immediately, no CPU_ACK; the next request after reset completes normally.
